reg_load_ctrl: RTL



---
 rtl/reg_load_ctrl_if.sv | 28 ++
 rtl/reg_load_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_load_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : reg_load_ctrl_if
//  Description : Reader-side bundle of the parameter-load sequencer: enable
//                strobe, per-camera address-mux modes and status flags.
//  Revision    : 1.0 - initial release
// ============================================================================
interface reg_load_ctrl_if;
  logic       o_rd_enable;
  logic [1:0] o_cam0_mode;
  logic [1:0] o_cam1_mode;
  logic       o_params_valid;
  logic       o_busy;
  logic       o_load_done;

  // Sequencer side drives the bundle.
  modport master (
    output o_rd_enable, o_cam0_mode, o_cam1_mode,
           o_params_valid, o_busy, o_load_done
  );

  // Register reader / transform datapath side observes it.
  modport slave (
    input  o_rd_enable, o_cam0_mode, o_cam1_mode,
           o_params_valid, o_busy, o_load_done
  );
endinterface
`default_nettype wire

// File: rtl/reg_load_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : reg_load_ctrl
//  Description : Debounces camera mode switches and sequences one full
//                parameter-reader sweep per reload, started on frame
//                boundaries, with ROM settle cycles before each strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_load_ctrl #(
  parameter int ROM_LAT      = 1,
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int SWEEP_LEN    = 128
) (
  input  logic             clk,
  input  logic             i_reset,
  input  logic [1:0]       i_cam0_mode_sw,
  input  logic [1:0]       i_cam1_mode_sw,
  input  logic             i_frame_start,
  input  logic             i_reload,
  reg_load_ctrl_if.master  rd_if
);

  localparam int c_DEB_W = $clog2(DEBOUNCE_CYC + 1);
  localparam int c_PH_W  = $clog2(SWEEP_LEN);
  localparam int c_ST_W  = $clog2(SWEEP_LEN + 1);

  localparam logic [c_DEB_W-1:0] c_DEB_LAST    = c_DEB_W'(DEBOUNCE_CYC - 1);
  localparam logic [c_PH_W-1:0]  c_PH_LAST     = c_PH_W'(SWEEP_LEN - 1);
  localparam logic [c_ST_W-1:0]  c_ST_LAST     = c_ST_W'(SWEEP_LEN - 1);
  localparam logic [c_ST_W-1:0]  c_ST_FULL     = c_ST_W'(SWEEP_LEN);
  localparam logic [3:0]         c_SETTLE_LOAD = (ROM_LAT == 0) ? 4'd0 : 4'(ROM_LAT - 1);
  localparam bit                 c_NO_SETTLE   = (ROM_LAT == 0);

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_STROBE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // --------------------------------------------------------------------------
  // Switch synchronisers and debouncers, index 0 = camera 0, 1 = camera 1
  // --------------------------------------------------------------------------
  logic [1:0]         sw_raw    [2];
  logic [1:0]         sync1_q   [2];
  logic [1:0]         sync2_q   [2];
  logic [1:0]         cand_q    [2];
  logic [1:0]         deb_q     [2];
  logic [c_DEB_W-1:0] deb_cnt_q [2];
  logic [1:0]         w_accept;

  assign sw_raw[0] = i_cam0_mode_sw;
  assign sw_raw[1] = i_cam1_mode_sw;

  // A new value is accepted on its DEBOUNCE_CYC-th consecutive identical sample.
  always_comb begin
    w_accept = '0;
    for (int c = 0; c < 2; c++) begin
      w_accept[c] = (sync2_q[c] != deb_q[c]) && (sync2_q[c] == cand_q[c]) &&
                    (deb_cnt_q[c] == c_DEB_LAST);
    end
  end

  // Two-flop synchronise each switch bit, then count a stable candidate.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      for (int c = 0; c < 2; c++) begin
        sync1_q[c]   <= '0;
        sync2_q[c]   <= '0;
        cand_q[c]    <= '0;
        deb_q[c]     <= '0;
        deb_cnt_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        sync1_q[c] <= sw_raw[c];
        sync2_q[c] <= sync1_q[c];
        if (sync2_q[c] == deb_q[c]) begin
          deb_cnt_q[c] <= '0;
        end else if (w_accept[c]) begin
          deb_q[c]     <= sync2_q[c];
          deb_cnt_q[c] <= '0;
        end else if ((sync2_q[c] != cand_q[c]) || (deb_cnt_q[c] == '0)) begin
          // Fresh candidate or a glitch to another value: this sample is the first.
          cand_q[c]    <= sync2_q[c];
          deb_cnt_q[c] <= c_DEB_W'(1);
        end else begin
          deb_cnt_q[c] <= deb_cnt_q[c] + c_DEB_W'(1);
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Sweep sequencer
  // --------------------------------------------------------------------------
  state_t             state_q;
  logic               rd_en_q;
  logic               busy_q;
  logic               valid_q;
  logic               done_q;
  logic               pending_q;
  logic [1:0]         mode0_q;
  logic [1:0]         mode1_q;
  logic [3:0]         settle_q;
  logic [c_ST_W-1:0]  strb_q;
  logic [c_PH_W-1:0]  phase_q;
  logic [c_PH_W-1:0]  phase_d;
  logic               w_event;
  logic               w_sweep_done;
  logic               w_start;
  logic               w_step;

  assign w_event      = i_reload | (|w_accept);
  assign phase_d      = (phase_q == c_PH_LAST) ? '0 : phase_q + c_PH_W'(1);
  // strb_q excludes the strobe being issued now, hence the compare against LEN-1.
  assign w_sweep_done = (strb_q >= c_ST_LAST) && (phase_d == '0);
  // Pending is looked at as registered, so a same-cycle event waits a frame.
  assign w_start      = (state_q == ST_INIT) ||
                        ((state_q == ST_IDLE) && pending_q && i_frame_start);
  assign w_step       = w_start || ((state_q == ST_STROBE) && !w_sweep_done);

  // Mirrors the reader's own unreset counter: it advances on every enable the
  // reader sees, including one in a cycle where reset is asserted. It relies on
  // power-up clearing, exactly as the reader's counter does.
  always_ff @(posedge clk) begin
    if (rd_en_q) begin
      phase_q <= phase_d;
    end
  end

  // Sweep FSM with registered outputs; each step is settle cycles then one strobe.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q   <= ST_INIT;
      rd_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      pending_q <= 1'b0;
      mode0_q   <= 2'b00;
      mode1_q   <= 2'b00;
      settle_q  <= '0;
      strb_q    <= '0;
    end else begin
      rd_en_q   <= 1'b0;
      done_q    <= 1'b0;
      pending_q <= pending_q | w_event;

      if (w_start) begin
        mode0_q   <= deb_q[0];
        mode1_q   <= deb_q[1];
        pending_q <= w_event;  // an event landing on the start edge is kept
        busy_q    <= 1'b1;
        valid_q   <= 1'b0;
        strb_q    <= '0;
      end else if ((state_q == ST_STROBE) && (strb_q != c_ST_FULL)) begin
        strb_q    <= strb_q + c_ST_W'(1);
      end

      if (w_step) begin
        if (c_NO_SETTLE) begin
          state_q <= ST_STROBE;
          rd_en_q <= 1'b1;
        end else begin
          state_q  <= ST_SETTLE;
          settle_q <= c_SETTLE_LOAD;
        end
      end else begin
        case (state_q)
          ST_IDLE: state_q <= ST_IDLE;
          ST_SETTLE: begin
            if (settle_q == '0) begin
              state_q <= ST_STROBE;
              rd_en_q <= 1'b1;
            end else begin
              settle_q <= settle_q - 4'd1;
            end
          end
          ST_STROBE: begin
            // Only reached here when the sweep is complete.
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
          end
          ST_DONE: state_q <= ST_IDLE;
          default: state_q <= ST_INIT;
        endcase
      end
    end
  end

  assign rd_if.o_rd_enable    = rd_en_q;
  assign rd_if.o_cam0_mode    = mode0_q;
  assign rd_if.o_cam1_mode    = mode1_q;
  assign rd_if.o_params_valid = valid_q;
  assign rd_if.o_busy         = busy_q;
  assign rd_if.o_load_done    = done_q;

endmodule
`default_nettype wire
